// File: rtl/mfcc_loop_scheduler.sv
// Two-level nested loop sequencer for the MFCC datapath.
// Issues (outer_idx, inner_idx) steps over a valid/ready handshake, then
// flush after each outer iteration and done after the full sweep.
// Ports: clk, rst (sync, active-high), start, inner_max, outer_max,
//   step_ready in; step_valid, inner_idx, outer_idx, inner_last,
//   outer_last, flush, busy, done out.
module mfcc_loop_scheduler #(
  parameter int IDX_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_WIDTH-1:0] inner_max,
  input  logic [IDX_WIDTH-1:0] outer_max,
  input  logic                 step_ready,
  output logic                 step_valid,
  output logic [IDX_WIDTH-1:0] inner_idx,
  output logic [IDX_WIDTH-1:0] outer_idx,
  output logic                 inner_last,
  output logic                 outer_last,
  output logic                 flush,
  output logic                 busy,
  output logic                 done
);

  localparam logic [IDX_WIDTH-1:0] ONE = IDX_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH,
    DONE
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [IDX_WIDTH-1:0] inner_n;
  logic [IDX_WIDTH-1:0] outer_n;
  logic [IDX_WIDTH-1:0] inner_max_q;
  logic [IDX_WIDTH-1:0] outer_max_q;
  logic [IDX_WIDTH-1:0] inner_max_n;
  logic [IDX_WIDTH-1:0] outer_max_n;
  logic                 inner_end;
  logic                 outer_end;

  // The bound compare happens before any increment, so an index sitting
  // at the all-ones bound is never incremented and cannot wrap.
  assign inner_end = (inner_idx == inner_max_q);
  assign outer_end = (outer_idx == outer_max_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      inner_idx   <= '0;
      outer_idx   <= '0;
      inner_max_q <= '0;
      outer_max_q <= '0;
    end else begin
      state       <= state_n;
      inner_idx   <= inner_n;
      outer_idx   <= outer_n;
      inner_max_q <= inner_max_n;
      outer_max_q <= outer_max_n;
    end
  end

  always_comb begin
    state_n     = state;
    inner_n     = inner_idx;
    outer_n     = outer_idx;
    inner_max_n = inner_max_q;
    outer_max_n = outer_max_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          inner_max_n = inner_max;
          outer_max_n = outer_max;
          inner_n     = '0;
          outer_n     = '0;
          state_n     = ISSUE;
        end
      end
      ISSUE: begin
        // Without ready, everything holds so valid stays up until taken.
        if (step_ready) begin
          if (inner_end) begin
            state_n = FLUSH;
          end else begin
            inner_n = inner_idx + ONE;
          end
        end
      end
      FLUSH: begin
        if (outer_end) begin
          state_n = DONE;
        end else begin
          outer_n = outer_idx + ONE;
          inner_n = '0;
          state_n = ISSUE;
        end
      end
      DONE: begin
        inner_n = '0;
        outer_n = '0;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pure state decodes: step_ready never reaches step_valid combinationally.
  assign step_valid = (state == ISSUE);
  assign flush      = (state == FLUSH);
  assign done       = (state == DONE);
  assign busy       = step_valid | flush;
  assign inner_last = step_valid & inner_end;
  assign outer_last = step_valid & outer_end;

endmodule

// File: tb/tb_mfcc_loop_scheduler.sv
// Testbench for mfcc_loop_scheduler.
// Scoreboard of expected steps, checked against accepted transfers.
module tb_mfcc_loop_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] inner_max;
  logic [7:0] outer_max;
  logic       step_ready;
  logic       step_valid;
  logic [7:0] inner_idx;
  logic [7:0] outer_idx;
  logic       inner_last;
  logic       outer_last;
  logic       flush;
  logic       busy;
  logic       done;

  typedef struct {
    int o;
    int i;
    bit il;
    bit ol;
  } step_t;

  step_t sq[$];
  int    fcq[$];
  int    busy_cnt;
  int    checks;
  int    failures;

  mfcc_loop_scheduler #(.IDX_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .inner_max (inner_max),
    .outer_max (outer_max),
    .step_ready(step_ready),
    .step_valid(step_valid),
    .inner_idx (inner_idx),
    .outer_idx (outer_idx),
    .inner_last(inner_last),
    .outer_last(outer_last),
    .flush     (flush),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Caller is positioned at posedge+#1; that cycle is cycle 0.
  task automatic do_sweep(input int im, input int om, input bit rnd,
                          input bit mess, input int rst_cyc,
                          output int done_cyc, output int ntr);
    int    cyc;
    bit    fin;
    bit    prev_v, prev_tr, prev_last, prev_fl;
    int    prev_o, prev_i;
    bit    exp_fl, exp_dn;
    step_t e;
    sq.delete();
    fcq.delete();
    busy_cnt = 0;
    done_cyc = -1;
    ntr      = 0;
    for (int o = 0; o <= om; o++)
      for (int i = 0; i <= im; i++)
        sq.push_back('{o: o, i: i, il: (i == im), ol: (o == om)});
    inner_max  = im[7:0];
    outer_max  = om[7:0];
    start      = 1'b1;
    step_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    checks++;
    if (step_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_c0 valid=%b busy=%b exp 0 0", step_valid, busy);
    end
    prev_v = 0; prev_tr = 0; prev_last = 0; prev_fl = 0;
    prev_o = 0; prev_i = 0;
    fin = 0;
    cyc = 0;
    while (!fin && cyc < 4000) begin
      @(posedge clk);
      #1;
      cyc++;
      exp_fl = prev_tr && prev_last;
      exp_dn = prev_fl && (prev_o == om);
      if (rst_cyc >= 0 && cyc == rst_cyc + 1) begin
        checks++;
        if ({step_valid, flush, busy, done, inner_last, outer_last} !== 6'b0
            || inner_idx !== 8'd0 || outer_idx !== 8'd0) begin
          failures++;
          $display("FAIL rst_outs v=%b f=%b b=%b d=%b i=%0d o=%0d exp all 0",
                   step_valid, flush, busy, done, inner_idx, outer_idx);
        end
        rst   = 1'b0;
        start = 1'b0;
        sq.delete();
        fin = 1;
      end else begin
        checks++;
        if (flush !== exp_fl) begin
          failures++;
          $display("FAIL flush c%0d got=%b exp=%b", cyc, flush, exp_fl);
        end
        checks++;
        if (done !== exp_dn) begin
          failures++;
          $display("FAIL done c%0d got=%b exp=%b", cyc, done, exp_dn);
        end
        checks++;
        if (busy !== (step_valid | flush) || (flush && step_valid)) begin
          failures++;
          $display("FAIL busy c%0d busy=%b valid=%b flush=%b",
                   cyc, busy, step_valid, flush);
        end
        if (prev_v && !prev_tr) begin
          checks++;
          if (step_valid !== 1'b1 || int'(inner_idx) != prev_i
              || int'(outer_idx) != prev_o) begin
            failures++;
            $display("FAIL stall c%0d v=%b o=%0d i=%0d exp 1 %0d %0d",
                     cyc, step_valid, outer_idx, inner_idx, prev_o, prev_i);
          end
        end
        if (busy) busy_cnt++;
        if (flush) fcq.push_back(cyc);
        if (done) begin
          done_cyc = cyc;
          fin = 1;
        end
        start = mess && step_valid;
        if (mess) begin
          inner_max = 8'd7;
          outer_max = 8'd7;
        end
        step_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rst_cyc == cyc) rst = 1'b1;
        prev_v    = step_valid;
        prev_tr   = step_valid && step_ready;
        prev_o    = int'(outer_idx);
        prev_i    = int'(inner_idx);
        prev_fl   = flush;
        prev_last = (int'(inner_idx) == im);
        if (prev_tr) begin
          ntr++;
          checks++;
          if (sq.size() == 0) begin
            failures++;
            $display("FAIL extra_step o=%0d i=%0d exp none",
                     outer_idx, inner_idx);
          end else begin
            e = sq.pop_front();
            if (int'(outer_idx) != e.o || int'(inner_idx) != e.i
                || inner_last !== e.il || outer_last !== e.ol) begin
              failures++;
              $display("FAIL step o=%0d i=%0d il=%b ol=%b exp %0d %0d %b %b",
                       outer_idx, inner_idx, inner_last, outer_last,
                       e.o, e.i, e.il, e.ol);
            end
          end
        end
      end
    end
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL timeout cycles=%0d exp done", cyc);
    end else if (rst_cyc < 0) begin
      checks++;
      if (sq.size() != 0) begin
        failures++;
        $display("FAIL missing_steps left=%0d exp 0", sq.size());
      end
      @(posedge clk);
      #1;
      checks++;
      if (step_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL post_idle v=%b d=%b b=%b exp 0 0 0",
                 step_valid, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    start      = 1'b0;
    step_ready = 1'b0;
    inner_max  = 8'd0;
    outer_max  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({step_valid, flush, busy, done, inner_last, outer_last} !== 6'b0
        || inner_idx !== 8'd0 || outer_idx !== 8'd0) begin
      failures++;
      $display("FAIL reset v=%b f=%b b=%b d=%b i=%0d o=%0d exp all 0",
               step_valid, flush, busy, done, inner_idx, outer_idx);
    end
  endtask

  task automatic test_single();
    int dc, nt;
    do_sweep(0, 0, 0, 0, -1, dc, nt);
    checks++;
    if (dc != 3 || nt != 1 || busy_cnt != 2) begin
      failures++;
      $display("FAIL single done=%0d n=%0d busy=%0d exp 3 1 2",
               dc, nt, busy_cnt);
    end
    checks++;
    if (fcq.size() != 1 || fcq[0] != 2) begin
      failures++;
      $display("FAIL single_flush n=%0d exp flush at 2", fcq.size());
    end
  endtask

  task automatic test_basic();
    int dc, nt;
    do_sweep(3, 2, 0, 0, -1, dc, nt);
    checks++;
    if (dc != 16 || nt != 12) begin
      failures++;
      $display("FAIL basic done=%0d n=%0d exp 16 12", dc, nt);
    end
    checks++;
    if (fcq.size() != 3 || fcq[0] != 5 || fcq[1] != 10 || fcq[2] != 15) begin
      failures++;
      $display("FAIL basic_flush n=%0d exp 5,10,15", fcq.size());
    end
  endtask

  task automatic test_stall();
    int dc, nt;
    do_sweep(3, 2, 1, 0, -1, dc, nt);
    checks++;
    if (nt != 12 || fcq.size() != 3) begin
      failures++;
      $display("FAIL stall_sweep n=%0d flushes=%0d exp 12 3", nt, fcq.size());
    end
  endtask

  task automatic test_ignore();
    int dc, nt;
    do_sweep(3, 2, 0, 1, -1, dc, nt);
    checks++;
    if (dc != 16 || nt != 12) begin
      failures++;
      $display("FAIL ignore done=%0d n=%0d exp 16 12", dc, nt);
    end
  endtask

  task automatic test_mid_reset();
    int dc, nt;
    do_sweep(3, 2, 0, 0, 6, dc, nt);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || step_valid !== 1'b0 || flush !== 1'b0) begin
        failures++;
        $display("FAIL rst_quiet d=%b v=%b f=%b exp 0 0 0",
                 done, step_valid, flush);
      end
    end
    do_sweep(3, 2, 0, 0, -1, dc, nt);
    checks++;
    if (dc != 16 || nt != 12) begin
      failures++;
      $display("FAIL rst_resweep done=%0d n=%0d exp 16 12", dc, nt);
    end
  endtask

  task automatic test_wide();
    int dc, nt;
    do_sweep(255, 1, 0, 0, -1, dc, nt);
    checks++;
    if (dc != 515 || nt != 512) begin
      failures++;
      $display("FAIL wide done=%0d n=%0d exp 515 512", dc, nt);
    end
  endtask

  task automatic test_back_to_back();
    bit [5:0] vexp;
    bit [5:0] dexp;
    vexp = 6'b010001;
    dexp = 6'b000100;
    inner_max  = 8'd0;
    outer_max  = 8'd0;
    step_ready = 1'b1;
    start      = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (step_valid !== vexp[c-1] || done !== dexp[c-1]) begin
        failures++;
        $display("FAIL b2b c%0d v=%b d=%b exp %b %b",
                 c, step_valid, done, vexp[c-1], dexp[c-1]);
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (step_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end v=%b b=%b exp 0 0", step_valid, busy);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_basic();
    test_stall();
    test_ignore();
    test_mid_reset();
    test_wide();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
